seg7_scan_driver: RTL and testbench
===================================

// Module: seg7_scan_driver
// PURPOSE
//  Parametrised multiplexed 7-segment driver, successor to the fixed 4-digit display path.
//  Captures a binary value on a load strobe, converts it to BCD with a sequential
//  double-dabble engine (or to hex nibbles), then time-multiplexes NUM_DIGITS digits.
//  Adds leading-zero blanking, overflow indication and selectable output polarity.
//  Sits between the processor result bus and the board anode/segment pins.
// PARAMETERS
//  NUM_DIGITS   4       digits driven (1..8)
//  DATA_W       16      width of data_in (4..32)
//  REFRESH_CNT  262144  clk_100mhz cycles each digit stays lit (>=2)
//  ACTIVE_LOW   1       1: anode/seg active-low; 0: both inverted to active-high
// PORTS
//  clk_100mhz  in   1           system clock, 100 MHz
//  reset       in   1           asynchronous, active-high
//  data_in     in   DATA_W      binary value to display
//  load        in   1           1-cycle strobe, captures data_in/hex_mode when busy=0
//  hex_mode    in   1           1: show hex nibbles; 0: show decimal
//  blank_lz    in   1           1: blank leading zeros (live, not captured)
//  busy        out  1           conversion in progress, load ignored
//  overflow    out  1           committed value does not fit NUM_DIGITS
//  anode       out  NUM_DIGITS  one-hot digit enable, bit0 = rightmost (LSD)
//  seg         out  7           segments {a,b,c,d,e,f,g}, seg[6]=a
// BEHAVIOUR
//  - Reset: anode all inactive, seg all off, busy=0, overflow=0, digit regs=0, scan idx=0,
//    refresh cnt=0, FSM=IDLE. Reset mid-conversion aborts; display reverts to 0.
//  - FSM IDLE->CONV->COMMIT->IDLE. load&&IDLE: capture data_in, hex_mode.
//    Decimal: CONV runs exactly DATA_W shift cycles (add-3 on BCD digits >=5, then shift).
//    Hex: IDLE->COMMIT directly. COMMIT (1 cycle) copies result to display regs + overflow.
//  - busy=1 in CONV and COMMIT; decimal busy = DATA_W+1 cycles, hex busy = 1 cycle.
//    Display updated in cycle after COMMIT. load while busy ignored, no queuing.
//  - BCD register width = enough digits for 2^DATA_W-1 (localparam). overflow=1 if any BCD
//    digit above NUM_DIGITS-1 nonzero (decimal) or data >= 16^NUM_DIGITS (hex).
//  - overflow=1: every digit shows dash (g only). Held until next COMMIT.
//  - Scan: refresh cnt 0..REFRESH_CNT-1; at terminal count idx advances, wraps
//    NUM_DIGITS-1 -> 0. Exactly one anode active at a time after first clock.
//  - anode/seg registered: one-cycle lag after idx/display change.
//  - Blanking: blank_lz=1 blanks digits above highest nonzero digit; digit 0 never
//    blanked. Blanked digit: anode still driven, all segments off.
//  - Active-low codes (ACTIVE_LOW=1): 0=0000001 1=1001111 2=0010010 3=0000110 4=1001100
//    5=0100100 6=0100000 7=0001111 8=0000000 9=0000100 A=0001000 b=1100000 C=0110001
//    d=1000010 E=0110000 F=0111000 dash=1111110 off=1111111. ACTIVE_LOW=0 inverts all.
// TESTING (NUM_DIGITS=4, DATA_W=16, REFRESH_CNT=4, ACTIVE_LOW=1)
//  1 assert reset -> anode=1111, seg=1111111, busy=0; release, blank_lz=0 -> each digit
//    seg=0000001, anode sequence 1110,1101,1011,0111 every 4 cycles, then wraps.
//  2 load 1234 decimal -> busy high 17 cycles; then 1110/1001100, 1101/0000110,
//    1011/0010010, 0111/1001111; overflow=0.
//  3 load 16'hBEEF hex_mode=1 -> busy 1 cycle; digits F,E,E,b =
//    0111000,0110000,0110000,1100000.
//  4 load 12345 decimal -> overflow=1, all four digits seg=1111110; load 9999 -> overflow=0.
//  5 blank_lz=1, load 7 -> digits 1-3 seg=1111111, digit0 0001111; load 0 -> digit0 0000001.
//  6 load 42 then load 99 on busy cycle 3 -> 99 ignored, 42 shown; reset in CONV cycle 8
//    -> busy=0, outputs at reset values, display 0 after release.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-segment driver: captures a binary value, converts it to BCD (or hex nibbles)
// with a sequential double-dabble engine, and scans the digits with optional leading-zero blanking.
module seg7_scan_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int DATA_W      = 16,
  parameter int REFRESH_CNT = 262144,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic                  clk_100mhz,
  input  logic                  reset,
  input  logic [DATA_W-1:0]     data_in,
  input  logic                  load,
  input  logic                  hex_mode,
  input  logic                  blank_lz,
  output logic                  busy,
  output logic                  overflow,
  output logic [NUM_DIGITS-1:0] anode,
  output logic [6:0]            seg
);

  // Decimal digits needed to hold 2^w-1.
  function automatic int bcd_digits_for(input int w);
    longint unsigned max_val;
    int n;
    max_val = (64'd1 << w) - 64'd1;
    n = 1;
    while (max_val >= 64'd10) begin
      max_val = max_val / 64'd10;
      n = n + 1;
    end
    return n;
  endfunction

  localparam int BCD_DIGITS = bcd_digits_for(DATA_W);
  localparam int BCD_W      = 4 * BCD_DIGITS;
  localparam int DD_W       = BCD_W + DATA_W;
  localparam int REF_W      = $clog2(REFRESH_CNT);
  localparam int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BIT_W      = $clog2(DATA_W);

  localparam logic [NUM_DIGITS-1:0] ANODE_OFF = {NUM_DIGITS{ACTIVE_LOW}};
  localparam logic [6:0]            SEG_OFF   = {7{ACTIVE_LOW}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                hex_q, hex_d;
  logic [BCD_W-1:0]    bcd_q, bcd_d;
  logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [3:0]          digits_q [NUM_DIGITS];
  logic [3:0]          digits_d [NUM_DIGITS];
  logic                overflow_q, overflow_d;
  logic [REF_W-1:0]    refresh_q, refresh_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [NUM_DIGITS-1:0] anode_q, anode_d;
  logic [6:0]          seg_q, seg_d;

  logic [DD_W-1:0]       dd_work;
  logic [63:0]           hex_ext;
  logic [63:0]           bcd_ext;
  logic [NUM_DIGITS-1:0] blank_vec;
  logic                  upper_zero;
  logic [3:0]            cur_digit;
  logic [6:0]            seg_raw;
  logic [NUM_DIGITS-1:0] anode_onehot;

  // Codes are stored active-low; the output stage flips them for active-high boards.
  function automatic logic [6:0] seg_code(input logic [3:0] v);
    case (v)
      4'h0: seg_code = 7'b0000001;
      4'h1: seg_code = 7'b1001111;
      4'h2: seg_code = 7'b0010010;
      4'h3: seg_code = 7'b0000110;
      4'h4: seg_code = 7'b1001100;
      4'h5: seg_code = 7'b0100100;
      4'h6: seg_code = 7'b0100000;
      4'h7: seg_code = 7'b0001111;
      4'h8: seg_code = 7'b0000000;
      4'h9: seg_code = 7'b0000100;
      4'hA: seg_code = 7'b0001000;
      4'hB: seg_code = 7'b1100000;
      4'hC: seg_code = 7'b0110001;
      4'hD: seg_code = 7'b1000010;
      4'hE: seg_code = 7'b0110000;
      default: seg_code = 7'b0111000;
    endcase
  endfunction

  assign hex_ext = 64'(data_q);
  assign bcd_ext = 64'(bcd_q);
  assign busy    = (state_q != IDLE);

  // One double-dabble step on the combined {bcd, binary} register: add 3, then shift.
  always_comb begin
    dd_work = {bcd_q, data_q};
    for (int j = 0; j < BCD_DIGITS; j++) begin
      if (dd_work[DATA_W + 4*j +: 4] >= 4'd5)
        dd_work[DATA_W + 4*j +: 4] = dd_work[DATA_W + 4*j +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    hex_d      = hex_q;
    bcd_d      = bcd_q;
    bit_cnt_d  = bit_cnt_q;
    digits_d   = digits_q;
    overflow_d = overflow_q;
    case (state_q)
      IDLE: begin
        if (load) begin
          data_d    = data_in;
          hex_d     = hex_mode;
          bcd_d     = '0;
          bit_cnt_d = '0;
          state_d   = hex_mode ? COMMIT : CONV;
        end
      end
      CONV: begin
        {bcd_d, data_d} = dd_work << 1;
        bit_cnt_d       = bit_cnt_q + 1'b1;
        if (bit_cnt_q == BIT_W'(DATA_W - 1))
          state_d = COMMIT;
      end
      COMMIT: begin
        for (int i = 0; i < NUM_DIGITS; i++)
          digits_d[i] = hex_q ? hex_ext[4*i +: 4] : bcd_ext[4*i +: 4];
        overflow_d = hex_q ? (|(hex_ext >> (4*NUM_DIGITS)))
                           : (|(bcd_ext >> (4*NUM_DIGITS)));
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    refresh_d = refresh_q + 1'b1;
    idx_d     = idx_q;
    if (refresh_q == REF_W'(REFRESH_CNT - 1)) begin
      refresh_d = '0;
      idx_d     = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end
  end

  // A digit is blanked when it and every digit above it are zero; digit 0 always shows.
  always_comb begin
    upper_zero = 1'b1;
    blank_vec  = '0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      upper_zero   = upper_zero && (digits_q[i] == 4'd0);
      blank_vec[i] = blank_lz && upper_zero;
    end
  end

  always_comb begin
    cur_digit    = digits_q[idx_q];
    anode_onehot = NUM_DIGITS'(1) << idx_q;
    if (overflow_q)
      seg_raw = 7'b1111110;
    else if (blank_vec[idx_q])
      seg_raw = 7'b1111111;
    else
      seg_raw = seg_code(cur_digit);
    seg_d   = ACTIVE_LOW ? seg_raw : ~seg_raw;
    anode_d = ACTIVE_LOW ? ~anode_onehot : anode_onehot;
  end

  always_ff @(posedge clk_100mhz or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      data_q     <= '0;
      hex_q      <= 1'b0;
      bcd_q      <= '0;
      bit_cnt_q  <= '0;
      digits_q   <= '{default: 4'd0};
      overflow_q <= 1'b0;
      refresh_q  <= '0;
      idx_q      <= '0;
      anode_q    <= ANODE_OFF;
      seg_q      <= SEG_OFF;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      hex_q      <= hex_d;
      bcd_q      <= bcd_d;
      bit_cnt_q  <= bit_cnt_d;
      digits_q   <= digits_d;
      overflow_q <= overflow_d;
      refresh_q  <= refresh_d;
      idx_q      <= idx_d;
      anode_q    <= anode_d;
      seg_q      <= seg_d;
    end
  end

  assign overflow = overflow_q;
  assign anode    = anode_q;
  assign seg      = seg_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: 4 digits, 16-bit data, 4-cycle refresh, active-low pins.
module tb_seg7_scan_driver;

  logic        clk_100mhz = 1'b0;
  logic        reset;
  logic [15:0] data_in;
  logic        load;
  logic        hex_mode;
  logic        blank_lz;
  logic        busy;
  logic        overflow;
  logic [3:0]  anode;
  logic [6:0]  seg;

  int checks = 0;
  int errors = 0;

  localparam logic [6:0] S0    = 7'b0000001;
  localparam logic [6:0] S1    = 7'b1001111;
  localparam logic [6:0] S2    = 7'b0010010;
  localparam logic [6:0] S3    = 7'b0000110;
  localparam logic [6:0] S4    = 7'b1001100;
  localparam logic [6:0] S7    = 7'b0001111;
  localparam logic [6:0] S9    = 7'b0000100;
  localparam logic [6:0] SB    = 7'b1100000;
  localparam logic [6:0] SE    = 7'b0110000;
  localparam logic [6:0] SF    = 7'b0111000;
  localparam logic [6:0] SDASH = 7'b1111110;
  localparam logic [6:0] SOFF  = 7'b1111111;

  always #5 clk_100mhz = ~clk_100mhz;

  seg7_scan_driver #(
    .NUM_DIGITS (4),
    .DATA_W     (16),
    .REFRESH_CNT(4),
    .ACTIVE_LOW (1'b1)
  ) dut (
    .clk_100mhz(clk_100mhz),
    .reset     (reset),
    .data_in   (data_in),
    .load      (load),
    .hex_mode  (hex_mode),
    .blank_lz  (blank_lz),
    .busy      (busy),
    .overflow  (overflow),
    .anode     (anode),
    .seg       (seg)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0b expected %0b", tag, observed, expected);
    end
  endtask

  // Presents a one-cycle load strobe; returns on the negedge just after it was sampled.
  task automatic applyStimulus(input logic [15:0] value, input logic hex);
    @(negedge clk_100mhz);
    data_in  = value;
    hex_mode = hex;
    load     = 1'b1;
    @(negedge clk_100mhz);
    load     = 1'b0;
  endtask

  task automatic measureBusy(output int cycles);
    cycles = 0;
    while (busy === 1'b1 && cycles < 100) begin
      cycles++;
      @(negedge clk_100mhz);
    end
  endtask

  // Expected segments packed as {digit3, digit2, digit1, digit0}.
  task automatic checkDigits(input string tag, input logic [27:0] exp_segs, input logic exp_ovf);
    logic [3:0] pat;
    repeat (2) @(negedge clk_100mhz);
    checkOutput($sformatf("%s_ovf", tag), {31'd0, overflow}, {31'd0, exp_ovf});
    for (int d = 0; d < 4; d++) begin
      pat = ~(4'b0001 << d);
      for (int k = 0; k < 40 && anode !== pat; k++) @(negedge clk_100mhz);
      checkOutput($sformatf("%s_anode%0d", tag, d), {28'd0, anode}, {28'd0, pat});
      checkOutput($sformatf("%s_seg%0d", tag, d), {25'd0, seg}, {25'd0, exp_segs[7*d +: 7]});
    end
  endtask

  initial begin
    int cyc;
    logic [3:0] exp_an;

    reset    = 1'b1;
    data_in  = '0;
    load     = 1'b0;
    hex_mode = 1'b0;
    blank_lz = 1'b0;
    repeat (3) @(negedge clk_100mhz);
    checkOutput("rst_anode", {28'd0, anode}, 32'b1111);
    checkOutput("rst_seg", {25'd0, seg}, {25'd0, SOFF});
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_ovf", {31'd0, overflow}, 32'd0);
    reset = 1'b0;

    for (int c = 0; c < 20; c++) begin
      @(negedge clk_100mhz);
      exp_an = ~(4'b0001 << ((c / 4) % 4));
      checkOutput($sformatf("scan_anode_c%0d", c), {28'd0, anode}, {28'd0, exp_an});
      checkOutput($sformatf("scan_seg_c%0d", c), {25'd0, seg}, {25'd0, S0});
    end

    applyStimulus(16'd1234, 1'b0);
    measureBusy(cyc);
    checkOutput("dec1234_busy", cyc, 32'd17);
    checkDigits("dec1234", {S1, S2, S3, S4}, 1'b0);

    applyStimulus(16'hBEEF, 1'b1);
    measureBusy(cyc);
    checkOutput("hexbeef_busy", cyc, 32'd1);
    checkDigits("hexbeef", {SB, SE, SE, SF}, 1'b0);

    applyStimulus(16'd12345, 1'b0);
    measureBusy(cyc);
    checkOutput("dec12345_busy", cyc, 32'd17);
    checkDigits("dec12345", {SDASH, SDASH, SDASH, SDASH}, 1'b1);

    applyStimulus(16'd9999, 1'b0);
    measureBusy(cyc);
    checkDigits("dec9999", {S9, S9, S9, S9}, 1'b0);

    blank_lz = 1'b1;
    applyStimulus(16'd7, 1'b0);
    measureBusy(cyc);
    checkDigits("blank7", {SOFF, SOFF, SOFF, S7}, 1'b0);

    applyStimulus(16'd0, 1'b0);
    measureBusy(cyc);
    checkDigits("blank0", {SOFF, SOFF, SOFF, S0}, 1'b0);
    blank_lz = 1'b0;

    // A second load in the third busy cycle must neither restart nor replace the conversion.
    applyStimulus(16'd42, 1'b0);
    @(negedge clk_100mhz);
    data_in = 16'd99;
    load    = 1'b1;
    @(negedge clk_100mhz);
    load    = 1'b0;
    measureBusy(cyc);
    checkOutput("ignored_load_busy", cyc, 32'd15);
    checkDigits("dec42", {S0, S0, S4, S2}, 1'b0);

    applyStimulus(16'd9876, 1'b0);
    repeat (7) @(negedge clk_100mhz);
    reset = 1'b1;
    #1;
    checkOutput("midrst_busy", {31'd0, busy}, 32'd0);
    checkOutput("midrst_anode", {28'd0, anode}, 32'b1111);
    checkOutput("midrst_seg", {25'd0, seg}, {25'd0, SOFF});
    checkOutput("midrst_ovf", {31'd0, overflow}, 32'd0);
    @(negedge clk_100mhz);
    reset = 1'b0;
    checkDigits("after_rst", {S0, S0, S0, S0}, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
